// File: rtl/lock_keypad_tx_if.sv
// rtl/lock_keypad_tx_if.sv - keypad, lock-verdict and status signals for lock_keypad_tx
interface lock_keypad_tx_if #(
  parameter int CODE_W   = 4,
  parameter int MAX_FAIL = 3
);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int DIG_W  = $clog2(CODE_W + 1);

  logic              key_valid;
  logic              key_bit;
  logic              key_clear;
  logic              key_enter;
  logic              unlocked_state;
  logic              filed_state;
  logic [CODE_W-1:0] password;
  logic              open;
  logic              busy;
  logic              lockout;
  logic [FAIL_W-1:0] fail_cnt;
  logic [DIG_W-1:0]  digit_cnt;
  logic              result_ok;
  logic              result_fail;
  logic              entry_err;

  modport master (
    output key_valid, key_bit, key_clear, key_enter, unlocked_state, filed_state,
    input  password, open, busy, lockout, fail_cnt, digit_cnt,
           result_ok, result_fail, entry_err
  );

  modport slave (
    input  key_valid, key_bit, key_clear, key_enter, unlocked_state, filed_state,
    output password, open, busy, lockout, fail_cnt, digit_cnt,
           result_ok, result_fail, entry_err
  );
endinterface

// File: rtl/lock_keypad_tx.sv
// rtl/lock_keypad_tx.sv - keypad code transmitter with failure lockout (LOCK_TX_MASK_EN hides partial entries)
module lock_keypad_tx #(
  parameter int CODE_W       = 4,
  parameter int MAX_FAIL     = 3,
  parameter int LOCKOUT_CYC  = 64,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  lock_keypad_tx_if.slave bus
);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int DIG_W  = $clog2(CODE_W + 1);
  localparam int T_W    = $clog2(RESP_TIMEOUT + 1);
  localparam int L_W    = $clog2(LOCKOUT_CYC + 1);

  localparam logic [1:0] ST_ENTRY   = 2'b00;
  localparam logic [1:0] ST_WAIT    = 2'b01;
  localparam logic [1:0] ST_LOCKOUT = 2'b10;

  logic [1:0]        state_q;
  logic [CODE_W-1:0] shift_q;
  logic [DIG_W-1:0]  dcnt_q;
  logic [FAIL_W-1:0] fail_q;
  logic [T_W-1:0]    tcnt_q;
  logic [L_W-1:0]    lcnt_q;
  logic              open_q;
  logic              ok_q;
  logic              fail_pulse_q;
  logic              err_q;

  logic              dcnt_full;
  logic              enter_ok;
  logic              enter_bad;
  logic              key_shift;
  logic              timeout;
  logic              verdict_ok;
  logic              verdict_fail;
  logic              lock_done;
  logic [FAIL_W-1:0] fail_inc;

  assign dcnt_full = (dcnt_q == DIG_W'(CODE_W));
  assign enter_ok  = (state_q == ST_ENTRY) && !bus.key_clear && bus.key_enter && dcnt_full;
  assign enter_bad = (state_q == ST_ENTRY) && !bus.key_clear && bus.key_enter && !dcnt_full;
  assign key_shift = (state_q == ST_ENTRY) && !bus.key_clear && !bus.key_enter
                     && bus.key_valid && !dcnt_full;
  assign timeout   = (tcnt_q == T_W'(RESP_TIMEOUT - 1));

  // Both verdicts high counts as a rejection, so ok needs filed_state low.
  assign verdict_ok   = (state_q == ST_WAIT) && bus.unlocked_state && !bus.filed_state;
  assign verdict_fail = (state_q == ST_WAIT) && (bus.filed_state || (!bus.unlocked_state && timeout));
  assign lock_done    = (state_q == ST_LOCKOUT) && (lcnt_q == L_W'(LOCKOUT_CYC - 1));
  assign fail_inc     = fail_q + FAIL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ENTRY;
      shift_q      <= '0;
      dcnt_q       <= '0;
      fail_q       <= '0;
      tcnt_q       <= '0;
      lcnt_q       <= '0;
      open_q       <= 1'b0;
      ok_q         <= 1'b0;
      fail_pulse_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      open_q       <= enter_ok;
      ok_q         <= verdict_ok;
      fail_pulse_q <= verdict_fail;
      err_q        <= enter_bad;

      if ((state_q == ST_ENTRY && bus.key_clear) || enter_bad || verdict_ok || verdict_fail) begin
        shift_q <= '0;
        dcnt_q  <= '0;
      end else if (key_shift) begin
        shift_q <= {shift_q[CODE_W-2:0], bus.key_bit};
        dcnt_q  <= dcnt_q + DIG_W'(1);
      end

      if (enter_ok) begin
        state_q <= ST_WAIT;
        tcnt_q  <= '0;
      end else if (verdict_ok) begin
        state_q <= ST_ENTRY;
        fail_q  <= '0;
      end else if (verdict_fail) begin
        // WAIT is only reachable with fail_q < MAX_FAIL, so fail_inc never wraps.
        fail_q <= fail_inc;
        if (fail_inc == FAIL_W'(MAX_FAIL)) begin
          state_q <= ST_LOCKOUT;
          lcnt_q  <= '0;
        end else begin
          state_q <= ST_ENTRY;
        end
      end else if (state_q == ST_WAIT) begin
        tcnt_q <= tcnt_q + T_W'(1);
      end else if (lock_done) begin
        state_q <= ST_ENTRY;
        fail_q  <= '0;
      end else if (state_q == ST_LOCKOUT) begin
        lcnt_q <= lcnt_q + L_W'(1);
      end else if (state_q != ST_ENTRY) begin
        state_q <= ST_ENTRY;
      end
    end
  end

`ifdef LOCK_TX_MASK_EN
  logic [CODE_W-1:0] pw_q;

  // The code appears on the lock bus only from the open cycle until the verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      pw_q <= '0;
    end else if (enter_ok) begin
      pw_q <= shift_q;
    end else if (state_q != ST_WAIT || verdict_ok || verdict_fail) begin
      pw_q <= '0;
    end
  end

  assign bus.password = pw_q;
`else
  assign bus.password = shift_q;
`endif

  assign bus.open        = open_q;
  assign bus.busy        = (state_q == ST_WAIT) || (state_q == ST_LOCKOUT);
  assign bus.lockout     = (state_q == ST_LOCKOUT);
  assign bus.fail_cnt    = fail_q;
  assign bus.digit_cnt   = dcnt_q;
  assign bus.result_ok   = ok_q;
  assign bus.result_fail = fail_pulse_q;
  assign bus.entry_err   = err_q;
endmodule

// File: tb/tb_lock_keypad_tx.sv
// tb/tb_lock_keypad_tx.sv - table-driven and scoreboard bench for lock_keypad_tx
module tb_lock_keypad_tx;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  lock_keypad_tx_if #(.CODE_W(4), .MAX_FAIL(3)) bus ();

  lock_keypad_tx #(.CODE_W(4), .MAX_FAIL(3), .LOCKOUT_CYC(64), .RESP_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       kv;
    logic       kb;
    logic       kc;
    logic       ke;
    int         dcnt;
    logic       err;
    logic       opn;
    logic [3:0] shift;
  } vec_t;

  logic [3:0] exp_pw_q[$];
  bit         exp_res_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pw_exp(input logic [3:0] shift, input logic shown);
`ifdef LOCK_TX_MASK_EN
    return shown ? shift : 4'b0000;
`else
    return shift;
`endif
  endfunction

  // Scoreboard: every open must match a queued code, every result pulse a queued verdict.
  always @(negedge clk) begin
    if (!reset && bus.open) begin
      if (exp_pw_q.size() == 0) chk("unexpected_open", 1, 0);
      else chk("open_password", int'(bus.password), int'(exp_pw_q.pop_front()));
    end
    if (!reset && (bus.result_ok || bus.result_fail)) begin
      if (exp_res_q.size() == 0) chk("unexpected_result", 1, 0);
      else chk("result_kind_ok", int'(bus.result_ok), int'(exp_res_q.pop_front()));
    end
  end

  task automatic idle_inputs();
    bus.key_valid = 0; bus.key_bit = 0; bus.key_clear = 0; bus.key_enter = 0;
    bus.unlocked_state = 0; bus.filed_state = 0;
  endtask

  task automatic submit(input logic [3:0] code);
    for (int i = 3; i >= 0; i--) begin
      bus.key_valid = 1; bus.key_bit = code[i];
      step();
    end
    bus.key_valid = 0; bus.key_bit = 0;
    bus.key_enter = 1;
    exp_pw_q.push_back(code);
    step();
    bus.key_enter = 0;
    chk("submit_open", int'(bus.open), 1);
    chk("submit_busy", int'(bus.busy), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_password"}, int'(bus.password), 0);
    chk({tag, "_open"}, int'(bus.open), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_lockout"}, int'(bus.lockout), 0);
    chk({tag, "_fail_cnt"}, int'(bus.fail_cnt), 0);
    chk({tag, "_digit_cnt"}, int'(bus.digit_cnt), 0);
    chk({tag, "_result_ok"}, int'(bus.result_ok), 0);
    chk({tag, "_result_fail"}, int'(bus.result_fail), 0);
    chk({tag, "_entry_err"}, int'(bus.entry_err), 0);
  endtask

  initial begin
    vec_t vecs[15];
    vecs[0]  = '{1, 1, 0, 0, 1, 0, 0, 4'b0001};
    vecs[1]  = '{1, 1, 0, 0, 2, 0, 0, 4'b0011};
    vecs[2]  = '{0, 0, 0, 1, 0, 1, 0, 4'b0000};
    vecs[3]  = '{1, 0, 0, 0, 1, 0, 0, 4'b0000};
    vecs[4]  = '{1, 1, 0, 0, 2, 0, 0, 4'b0001};
    vecs[5]  = '{1, 1, 0, 0, 3, 0, 0, 4'b0011};
    vecs[6]  = '{1, 1, 0, 0, 4, 0, 0, 4'b0111};
    vecs[7]  = '{1, 1, 0, 0, 4, 0, 0, 4'b0111};
    vecs[8]  = '{1, 0, 0, 0, 4, 0, 0, 4'b0111};
    vecs[9]  = '{1, 1, 1, 1, 0, 0, 0, 4'b0000};
    vecs[10] = '{1, 1, 0, 0, 1, 0, 0, 4'b0001};
    vecs[11] = '{1, 0, 0, 0, 2, 0, 0, 4'b0010};
    vecs[12] = '{1, 1, 0, 0, 3, 0, 0, 4'b0101};
    vecs[13] = '{1, 0, 0, 0, 4, 0, 0, 4'b1010};
    vecs[14] = '{0, 0, 0, 1, 4, 0, 1, 4'b1010};

    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    check_reset_outputs("reset");

    for (int i = 0; i < 15; i++) begin
      bus.key_valid = vecs[i].kv; bus.key_bit = vecs[i].kb;
      bus.key_clear = vecs[i].kc; bus.key_enter = vecs[i].ke;
      if (vecs[i].opn) exp_pw_q.push_back(vecs[i].shift);
      step();
      chk($sformatf("vec%0d_digit_cnt", i), int'(bus.digit_cnt), vecs[i].dcnt);
      chk($sformatf("vec%0d_entry_err", i), int'(bus.entry_err), int'(vecs[i].err));
      chk($sformatf("vec%0d_open", i), int'(bus.open), int'(vecs[i].opn));
      chk($sformatf("vec%0d_busy", i), int'(bus.busy), int'(vecs[i].opn));
      chk($sformatf("vec%0d_password", i), int'(bus.password),
          int'(pw_exp(vecs[i].shift, vecs[i].opn)));
    end
    idle_inputs();

    // Open drops after one cycle, keys ignored and code held during WAIT.
    bus.key_valid = 1; bus.key_bit = 1;
    step();
    bus.key_valid = 0;
    chk("wait_open_drop", int'(bus.open), 0);
    chk("wait_busy", int'(bus.busy), 1);
    chk("wait_password", int'(bus.password), 4'b1010);
    chk("wait_digit_cnt", int'(bus.digit_cnt), 4);
    bus.unlocked_state = 1;
    exp_res_q.push_back(1'b1);
    step();
    bus.unlocked_state = 0;
    chk("unlock_result_ok", int'(bus.result_ok), 1);
    chk("unlock_fail_cnt", int'(bus.fail_cnt), 0);
    chk("unlock_busy", int'(bus.busy), 0);
    chk("unlock_password", int'(bus.password), 0);
    step();
    chk("unlock_pulse_width", int'(bus.result_ok), 0);

    // Three rejections lead to lockout.
    for (int f = 1; f <= 3; f++) begin
      submit(4'(4'b1100 + f));
      step();
      bus.filed_state = 1;
      exp_res_q.push_back(1'b0);
      step();
      bus.filed_state = 0;
      chk($sformatf("reject%0d_result_fail", f), int'(bus.result_fail), 1);
      chk($sformatf("reject%0d_fail_cnt", f), int'(bus.fail_cnt), f);
      chk($sformatf("reject%0d_lockout", f), int'(bus.lockout), f == 3 ? 1 : 0);
    end
    bus.key_enter = 1;
    for (int c = 1; c < 64; c++) begin
      step();
      if (!bus.lockout || bus.open) begin
        chk("lockout_hold", int'(bus.lockout), 1);
        chk("lockout_no_open", int'(bus.open), 0);
      end
    end
    chk("lockout_last_cycle", int'(bus.lockout), 1);
    step();
    bus.key_enter = 0;
    chk("lockout_end", int'(bus.lockout), 0);
    chk("lockout_fail_clear", int'(bus.fail_cnt), 0);
    chk("lockout_busy_clear", int'(bus.busy), 0);
    submit(4'b0110);
    bus.unlocked_state = 1;
    exp_res_q.push_back(1'b1);
    step();
    bus.unlocked_state = 0;
    chk("post_lockout_ok", int'(bus.result_ok), 1);

    // Verdict timeout fires RESP_TIMEOUT edges after the open edge.
    submit(4'b1001);
    exp_res_q.push_back(1'b0);
    for (int c = 1; c < 16; c++) begin
      step();
      if (bus.result_fail || !bus.busy) chk("timeout_early", int'(bus.result_fail), 0);
    end
    step();
    chk("timeout_result_fail", int'(bus.result_fail), 1);
    chk("timeout_fail_cnt", int'(bus.fail_cnt), 1);
    chk("timeout_state_entry", int'(bus.busy), 0);

    // Both verdicts together count as a rejection.
    submit(4'b0011);
    bus.unlocked_state = 1; bus.filed_state = 1;
    exp_res_q.push_back(1'b0);
    step();
    idle_inputs();
    chk("both_result_ok", int'(bus.result_ok), 0);
    chk("both_result_fail", int'(bus.result_fail), 1);
    chk("both_fail_cnt", int'(bus.fail_cnt), 2);

    // Reset in the middle of WAIT.
    submit(4'b1111);
    step();
    reset = 1;
    step();
    check_reset_outputs("midwait_reset");
    reset = 0;
    step();
    check_reset_outputs("after_reset");

    chk("pending_codes", exp_pw_q.size(), 0);
    chk("pending_results", exp_res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lock_keypad_tx.md
# lock_keypad_tx

Keypad-side code transmitter for the digital lock. It shifts in user key bits and forms a CODE_W-bit code. On enter, it presents the code with a one-cycle `open` strobe to the lock and waits for the lock's `unlocked_state`/`filed_state` verdict. It tracks consecutive failures and imposes a timed lockout, so it sits between the keypad front end and the lock's `password`/`open` inputs.

## Interface
- `CODE_W`, 4, code width in bits
- `MAX_FAIL`, 3, consecutive failures that trigger lockout (≥1)
- `LOCKOUT_CYC`, 64, lockout duration in clk cycles (≥1)
- `RESP_TIMEOUT`, 16, cycles to wait for a lock verdict before declaring failure (≥1)

- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `key_valid` in 1: one-cycle strobe, new key bit present
- `key_bit` in 1: key bit value, sampled with `key_valid`
- `key_clear` in 1: discard the partial entry
- `key_enter` in 1: submit the entry
- `unlocked_state` in 1: lock verdict, code accepted
- `filed_state` in 1: lock verdict, code rejected
- `password` out CODE_W: code to the lock
- `open` out 1: one-cycle submit strobe to the lock
- `busy` out 1: high in WAIT or LOCKOUT
- `lockout` out 1: high in LOCKOUT
- `fail_cnt` out $clog2(MAX_FAIL+1): consecutive failure count
- `digit_cnt` out $clog2(CODE_W+1): bits entered so far
- `result_ok` out 1: one-cycle pulse when an unlock is confirmed
- `result_fail` out 1: one-cycle pulse on a reject or timeout
- `entry_err` out 1: one-cycle pulse on an enter with an incomplete code

## Operation
- States: ENTRY, WAIT, LOCKOUT. Reset → ENTRY.
- ENTRY, input priority is `key_clear` > `key_enter` > `key_valid`:
  - `key_clear`: shift register ← 0, `digit_cnt` ← 0.
  - `key_enter` with `digit_cnt`==CODE_W: `open` ← 1 for exactly one cycle, state → WAIT, timeout counter ← 0.
  - `key_enter` with `digit_cnt`<CODE_W: `entry_err` pulse, shift register and `digit_cnt` cleared, stay in ENTRY.
  - `key_valid`: shift ← {shift[CODE_W-2:0], `key_bit`}, so the first bit lands in the MSB after CODE_W keys. `digit_cnt` increments and saturates at CODE_W. Keys beyond CODE_W are ignored and the shift register is unchanged.
- WAIT:
  - `password` is held stable and all key inputs are ignored.
  - `unlocked_state`=1: `result_ok` pulse, `fail_cnt` ← 0, entry cleared, → ENTRY.
  - `filed_state`=1, or both verdicts high (treated as failure): `result_fail` pulse, entry cleared, `fail_cnt` increments.
    - If the new count == MAX_FAIL → LOCKOUT, else → ENTRY.
  - No verdict for RESP_TIMEOUT sampled cycles is handled identically to `filed_state`.
- LOCKOUT:
  - `lockout`=1 and keys are ignored.
  - After LOCKOUT_CYC cycles: `fail_cnt` ← 0, → ENTRY.
- `fail_cnt` saturates at MAX_FAIL. `open` is never asserted outside the ENTRY→WAIT transition.

## Timing
- All outputs are registered.
- Reset values: `password`=0, `open`=0, `busy`=0, `lockout`=0, `fail_cnt`=0, `digit_cnt`=0, `result_ok`=0, `result_fail`=0, `entry_err`=0.
- Accepting `key_enter` at edge k makes `open`=1 and `busy`=1 during cycle k→k+1. `open` drops at edge k+1.
- Verdict sampling starts at edge k+1. The timeout fires at edge k+RESP_TIMEOUT if no verdict was seen at edges k+1..k+RESP_TIMEOUT.
- A verdict at edge v produces a result pulse in cycle v→v+1, and the state changes at the same edge. A new entry is accepted from edge v+1.
- Entering LOCKOUT at edge v holds `lockout`=1 for cycles v..v+LOCKOUT_CYC−1. ENTRY resumes at edge v+LOCKOUT_CYC.
- Verdicts arriving in ENTRY or LOCKOUT are ignored.
- `reset` mid-WAIT or mid-LOCKOUT returns everything to reset values at the next edge. No `open` is issued.

## Configuration
- `LOCK_TX_MASK_EN` defined:
  - `password` is driven 0 in ENTRY and LOCKOUT.
  - The code is driven onto `password` only in the `open` cycle and throughout WAIT, so the lock bus never shows partial entries.
- `LOCK_TX_MASK_EN` undefined: `password` continuously mirrors the shift register, and the value is frozen during WAIT.

## Test plan
- Reset, then keys 1,0,1,0 and enter → `password`=4'b1010, `open` high for exactly 1 cycle, `busy`=1. Drive `unlocked_state` 2 cycles later → `result_ok` pulse, `fail_cnt`=0, state ENTRY.
- Keys 1,1 then enter → `entry_err` pulse, no `open`, `digit_cnt`=0. Keys 0,1,1,1,1,0 then enter → `password`=4'b0111, and the 5th/6th keys are ignored.
- Three submissions each answered with `filed_state` → `fail_cnt` 1,2,3. After the 3rd: `lockout`=1 for 64 cycles, enter pressed during lockout produces no `open`, then `fail_cnt`=0 and a new entry is accepted.
- Submit and give no verdict → `result_fail` 16 cycles after the `open` edge, `fail_cnt`=1. Assert `unlocked_state` and `filed_state` together on the next submission → `result_fail`, `fail_cnt`=2.
- `key_clear`, `key_enter` and `key_valid` in the same cycle with 4 digits entered → clear wins, no `open`, `digit_cnt`=0. `reset` asserted during WAIT → all outputs return to reset values the next cycle.
- With `LOCK_TX_MASK_EN`: `password`=0 while keys are entered, equals the code from the `open` cycle through WAIT, and returns to 0 after the verdict.
